// File: rtl/image_scaler_controller.sv
// Maps a screen pixel (x,y) onto a stored image that is upscaled by 2^SCALE_LOG2 and optionally mirrored.
// Latency: mem_addr one cycle after x/y are sampled; memRGB/in_image 2+MEM_LAT cycles after sampling.
// Backpressure: none on the pixel path; a new position request is held off (pos_ready low) until the pending one lands on a frame edge.
module image_scaler_controller #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 15,
  parameter int MEM_LAT    = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              FRAME_CLOCK,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_flip,
  input  logic              pos_valid,
  output logic              pos_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  memRGB,
  output logic              in_image
);

  // Scaled image extent on screen.
  localparam int unsigned W_LIM = IMG_W << SCALE_LOG2;
  localparam int unsigned H_LIM = IMG_H << SCALE_LOG2;

  typedef enum logic [1:0] {S_READY, S_PEND, S_RELEASE} req_state_t;

  req_state_t state, state_nxt;
  logic       frame_prev;
  logic       frame_edge;
  logic       accept;
  logic       apply;
  logic [9:0] pend_x, pend_y;
  logic       pend_flip;
  logic [9:0] org_x, org_y;
  logic       org_flip;

  logic signed [10:0] dx_c, dy_c;
  logic               inside_c;
  logic signed [10:0] s1_dx, s1_dy;
  logic               s1_inside;
  logic               s1_flip;
  logic [31:0]        row_c, col_c;
  logic [MEM_LAT:0]   inside_sr;

  assign frame_edge = FRAME_CLOCK & ~frame_prev;

  // Request handshake state register.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) state <= S_READY;
    else        state <= state_nxt;
  end

  // Next state: accept one request, hold it until a frame edge, then reopen one cycle later.
  always_comb begin
    state_nxt = state;
    pos_ready = 1'b0;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state)
      S_READY: begin
        pos_ready = 1'b1;
        if (pos_valid) begin
          accept    = 1'b1;
          state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        // Only a request captured in an earlier cycle can be applied here.
        if (frame_edge) begin
          apply     = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: state_nxt = S_READY;
      default:   state_nxt = S_READY;
    endcase
  end

  // Frame edge sampling, pending capture and frame-synchronous origin update.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      frame_prev <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_flip  <= 1'b0;
      org_x      <= '0;
      org_y      <= '0;
      org_flip   <= 1'b0;
    end else begin
      frame_prev <= FRAME_CLOCK;
      if (accept) begin
        pend_x    <= pos_x;
        pend_y    <= pos_y;
        pend_flip <= pos_flip;
      end
      if (apply) begin
        org_x    <= pend_x;
        org_y    <= pend_y;
        org_flip <= pend_flip;
      end
    end
  end

  // Stage 1 combinational: signed offsets from the origin and the inside test.
  always_comb begin
    dx_c     = $signed({1'b0, x}) - $signed({1'b0, org_x});
    dy_c     = $signed({1'b0, y}) - $signed({1'b0, org_y});
    inside_c = !dx_c[10] && ({21'd0, dx_c} < 32'(W_LIM)) &&
               !dy_c[10] && ({21'd0, dy_c} < 32'(H_LIM));
  end

  // Stage 2 combinational: downscale offsets to stored row/column, mirroring the column if flipped.
  always_comb begin
    row_c = {21'd0, s1_dy} >> SCALE_LOG2;
    col_c = {21'd0, s1_dx} >> SCALE_LOG2;
    if (s1_flip) col_c = 32'(IMG_W - 1) - col_c;
  end

  // Pixel pipeline: stage 1 regs, stage 2 address, inside delay matching memory latency, output select.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_inside <= 1'b0;
      s1_flip   <= 1'b0;
      mem_addr  <= '0;
      inside_sr <= '0;
      memRGB    <= BG_COLOR;
      in_image  <= 1'b0;
    end else begin
      s1_dx     <= dx_c;
      s1_dy     <= dy_c;
      s1_inside <= inside_c;
      s1_flip   <= org_flip;
      mem_addr  <= s1_inside ? ADDR_W'(32'(IMG_W) * row_c + col_c) : '0;
      inside_sr <= {inside_sr[MEM_LAT-1:0], s1_inside};
      memRGB    <= inside_sr[MEM_LAT] ? mem_rdata : BG_COLOR;
      in_image  <= inside_sr[MEM_LAT];
    end
  end

endmodule

// File: tb/tb_image_scaler_controller.sv
// Bench for image_scaler_controller: directed cases plus random pixel streams against a reference model.
// Outputs are sampled on the falling edge; inputs change just after the falling edge.
// The image memory is modelled with one cycle of read latency.
`timescale 1ns/1ps
module tb_image_scaler_controller;

  localparam int IMG_W  = 160;
  localparam int IMG_H  = 120;
  localparam int SC     = 2;
  localparam int SF     = 1 << SC;
  localparam int HN     = 4096;
  localparam logic [7:0] BG = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fc = 1'b0;
  logic [9:0]  x = '0, y = '0, pos_x = '0, pos_y = '0;
  logic        pos_flip = 1'b0, pos_valid = 1'b0;
  logic        pos_ready;
  logic [14:0] mem_addr;
  logic [7:0]  mem_rdata, memRGB;
  logic        in_image;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: what the screen should be using, at the level of origin/request rules.
  int m_ox, m_oy, m_pox, m_poy;
  bit m_flip, m_pflip, m_pend, m_ready, m_release, m_fc_prev;
  logic [14:0] e_addr [HN];
  logic [7:0]  e_rgb  [HN];
  logic        e_in   [HN];

  always #5 clk = ~clk;

  image_scaler_controller #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_LOG2(SC), .PIX_W(8),
    .ADDR_W(15), .MEM_LAT(1), .BG_COLOR(BG)
  ) dut (
    .CLK_IN(clk), .RST_IN(rst), .FRAME_CLOCK(fc),
    .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y), .pos_flip(pos_flip),
    .pos_valid(pos_valid), .pos_ready(pos_ready),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .memRGB(memRGB), .in_image(in_image)
  );

  function automatic logic [7:0] pix(input logic [14:0] a);
    logic [31:0] t;
    t = {17'd0, a};
    return 8'(t * 7) ^ 8'(t >> 7) ^ 8'h5A;
  endfunction

  // Image memory with one cycle read latency.
  always @(posedge clk) mem_rdata <= pix(mem_addr);

  task automatic model_reset();
    m_ox = 0; m_oy = 0; m_flip = 0;
    m_pox = 0; m_poy = 0; m_pflip = 0; m_pend = 0;
    m_ready = 1; m_release = 0; m_fc_prev = 0;
  endtask

  // Drive one cycle of inputs, record the model's expectation for this pixel, advance to the next falling edge.
  task automatic tick(input int tx, input int ty, input bit tfc, input bit tpv,
                      input int tpx, input int tpy, input bit tpf);
    int dx, dy, col, a, k;
    bit ins, acc, app;
    x = 10'(tx); y = 10'(ty); fc = tfc;
    pos_valid = tpv; pos_x = 10'(tpx); pos_y = 10'(tpy); pos_flip = tpf;
    dx  = int'(x) - m_ox;
    dy  = int'(y) - m_oy;
    ins = (dx >= 0) && (dx < IMG_W * SF) && (dy >= 0) && (dy < IMG_H * SF);
    col = m_flip ? (IMG_W - 1 - dx / SF) : dx / SF;
    a   = ins ? (IMG_W * (dy / SF) + col) % 32768 : 0;
    k   = cyc % HN;
    e_addr[k] = 15'(a);
    e_in[k]   = ins;
    e_rgb[k]  = ins ? pix(15'(a)) : BG;
    acc = tpv && m_ready;
    app = tfc && !m_fc_prev && m_pend;
    m_fc_prev = tfc;
    if (m_release) begin m_ready = 1; m_release = 0; end
    if (app) begin
      m_ox = m_pox; m_oy = m_poy; m_flip = m_pflip; m_pend = 0; m_release = 1;
    end
    if (acc) begin
      m_pox = int'(pos_x); m_poy = int'(pos_y); m_pflip = pos_flip; m_pend = 1; m_ready = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; fc = 0; pos_valid = 0; x = 0; y = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    cyc++;
  endtask

  // Request an origin, raise a frame edge and wait until the port reopens.
  task automatic set_origin(input int ox, input int oy, input bit f);
    tick(0, 0, 0, 1, ox, oy, f);
    tick(0, 0, 1, 0, 0, 0, 0);
    idle();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if (memRGB !== BG) begin errors++; $display("FAIL reset_rgb: got %0h expected %0h", memRGB, BG); end
    checks++; if (in_image !== 1'b0) begin errors++; $display("FAIL reset_in_image: got %0b expected 0", in_image); end
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL reset_pos_ready: got %0b expected 1", pos_ready); end
  endtask

  task automatic test_basic();
    tick(5, 9, 0, 0, 0, 0, 0);
    idle();
    checks++; if (mem_addr !== 15'd321) begin errors++; $display("FAIL basic_addr: got %0d expected 321", mem_addr); end
    idle();
    idle();
    checks++; if (memRGB !== pix(15'd321)) begin errors++; $display("FAIL basic_rgb: got %0h expected %0h", memRGB, pix(15'd321)); end
    checks++; if (in_image !== 1'b1) begin errors++; $display("FAIL basic_in_image: got %0b expected 1", in_image); end
  endtask

  task automatic test_origin();
    tick(0, 0, 0, 1, 100, 50, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL origin_ready_low: got %0b expected 0", pos_ready); end
    tick(0, 0, 1, 0, 0, 0, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL origin_ready_edge: got %0b expected 0", pos_ready); end
    tick(99, 50, 0, 0, 0, 0, 0);
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL origin_ready_back: got %0b expected 1", pos_ready); end
    tick(100, 50, 0, 0, 0, 0, 0);
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL origin_addr_left: got %0d expected 0", mem_addr); end
    tick(101, 54, 0, 0, 0, 0, 0);
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL origin_addr_corner: got %0d expected 0", mem_addr); end
    idle();
    checks++; if (mem_addr !== 15'd160) begin errors++; $display("FAIL origin_addr_next: got %0d expected 160", mem_addr); end
    checks++; if (in_image !== 1'b0 || memRGB !== BG) begin errors++; $display("FAIL origin_outside: got in=%0b rgb=%0h expected in=0 rgb=%0h", in_image, memRGB, BG); end
    idle();
    checks++; if (in_image !== 1'b1 || memRGB !== pix(15'd0)) begin errors++; $display("FAIL origin_inside: got in=%0b rgb=%0h expected in=1 rgb=%0h", in_image, memRGB, pix(15'd0)); end
  endtask

  task automatic test_double_request();
    tick(0, 0, 0, 1, 10, 20, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL double_ready_first: got %0b expected 0", pos_ready); end
    tick(0, 0, 0, 1, 300, 300, 1);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL double_ready_second: got %0b expected 0", pos_ready); end
    tick(0, 0, 1, 0, 0, 0, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL double_ready_edge: got %0b expected 0", pos_ready); end
    idle();
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL double_ready_after: got %0b expected 1", pos_ready); end
    tick(14, 24, 0, 0, 0, 0, 0);
    idle();
    checks++; if (mem_addr !== 15'd161) begin errors++; $display("FAIL double_first_applied: got %0d expected 161", mem_addr); end
  endtask

  task automatic test_request_on_edge();
    tick(14, 24, 1, 1, 0, 0, 1);
    idle();
    checks++; if (mem_addr !== 15'd161) begin errors++; $display("FAIL edge_pixel_old: got %0d expected 161", mem_addr); end
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL edge_ready: got %0b expected 0", pos_ready); end
    tick(14, 24, 0, 0, 0, 0, 0);
    idle();
    checks++; if (mem_addr !== 15'd161) begin errors++; $display("FAIL edge_not_applied: got %0d expected 161", mem_addr); end
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    idle();
    checks++; if (mem_addr !== 15'd159) begin errors++; $display("FAIL edge_applied_next: got %0d expected 159", mem_addr); end
  endtask

  task automatic test_flip();
    set_origin(0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(639, 0, 0, 0, 0, 0, 0);
    checks++; if (mem_addr !== 15'd159) begin errors++; $display("FAIL flip_left: got %0d expected 159", mem_addr); end
    idle();
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL flip_right: got %0d expected 0", mem_addr); end
  endtask

  task automatic test_bounds();
    set_origin(0, 0, 0);
    tick(639, 479, 0, 0, 0, 0, 0);
    tick(639, 480, 0, 0, 0, 0, 0);
    checks++; if (mem_addr !== 15'd19199) begin errors++; $display("FAIL bounds_last_addr: got %0d expected 19199", mem_addr); end
    idle();
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL bounds_below_addr: got %0d expected 0", mem_addr); end
    idle();
    checks++; if (in_image !== 1'b1 || memRGB !== pix(15'd19199)) begin errors++; $display("FAIL bounds_last_pix: got in=%0b rgb=%0h expected in=1 rgb=%0h", in_image, memRGB, pix(15'd19199)); end
    idle();
    checks++; if (in_image !== 1'b0 || memRGB !== BG) begin errors++; $display("FAIL bounds_below_pix: got in=%0b rgb=%0h expected in=0 rgb=%0h", in_image, memRGB, BG); end
  endtask

  task automatic test_reset_pending();
    set_origin(4, 4, 0);
    tick(0, 0, 0, 1, 200, 200, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL rstpend_ready_low: got %0b expected 0", pos_ready); end
    do_reset();
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL rstpend_ready_reset: got %0b expected 1", pos_ready); end
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL rstpend_ready_edge: got %0b expected 1", pos_ready); end
    tick(5, 9, 0, 0, 0, 0, 0);
    idle();
    checks++; if (mem_addr !== 15'd321) begin errors++; $display("FAIL rstpend_origin: got %0d expected 321", mem_addr); end
  endtask

  // Random pixels while origins are requested, spammed with ignored requests, and applied on frame edges.
  task automatic test_random();
    int start, tox, toy, px, py, k;
    bit tf, pv, pf;
    start = cyc;
    for (int r = 0; r < 20; r++) begin
      tox = $urandom_range(0, 400);
      toy = $urandom_range(0, 300);
      tf  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 67; i++) begin
        pv = 0; px = tox; py = toy; pf = tf;
        if (i == 0) pv = 1;
        else if (i < 31) begin
          pv = 1'($urandom_range(0, 1));
          px = $urandom_range(0, 1023);
          py = $urandom_range(0, 1023);
          pf = 1'($urandom_range(0, 1));
        end
        tick(m_ox + $urandom_range(0, 700) - 30, m_oy + $urandom_range(0, 540) - 30,
             (i == 31), pv, px, py, pf);
        checks++;
        if (pos_ready !== m_ready) begin errors++; $display("FAIL rand_ready cyc %0d: got %0b expected %0b", cyc, pos_ready, m_ready); end
        if (cyc - 2 >= start) begin
          k = (cyc - 2) % HN;
          checks++;
          if (mem_addr !== e_addr[k]) begin errors++; $display("FAIL rand_addr cyc %0d: got %0d expected %0d", cyc, mem_addr, e_addr[k]); end
        end
        if (cyc - 4 >= start) begin
          k = (cyc - 4) % HN;
          checks++;
          if (memRGB !== e_rgb[k] || in_image !== e_in[k]) begin
            errors++;
            $display("FAIL rand_pix cyc %0d: got in=%0b rgb=%0h expected in=%0b rgb=%0h", cyc, in_image, memRGB, e_in[k], e_rgb[k]);
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_origin();
    test_double_request();
    test_request_on_edge();
    test_flip();
    test_bounds();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_scaler_controller.md
IMAGE_SCALER_CONTROLLER -- requirements
Module: image_scaler_controller

Interface
REQ-001 SHALL have parameter IMG_W, default 160, stored image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 120, stored image height in pixels.
REQ-003 SHALL have parameter SCALE_LOG2, default 2, upscale factor 2^SCALE_LOG2 in each axis.
REQ-004 SHALL have parameter PIX_W, default 8, pixel/colour width.
REQ-005 SHALL have parameter ADDR_W, default 15, memory address width, at least clog2(IMG_W*IMG_H).
REQ-006 SHALL have parameter MEM_LAT, default 1, image memory read latency in cycles, range 1..4.
REQ-007 SHALL have parameter BG_COLOR, default 0, colour output outside the image.
REQ-008 SHALL have ports (name, direction, width, meaning):
- CLK_IN, in, 1, the only clock.
- RST_IN, in, 1, reset; synchronous, active-high.
- FRAME_CLOCK, in, 1, frame-start level signal; its rising edge is detected in CLK_IN.
- x, in, 10, current pixel column.
- y, in, 10, current pixel row.
- pos_x, in, 10, requested image origin column.
- pos_y, in, 10, requested image origin row.
- pos_flip, in, 1, requested horizontal mirror.
- pos_valid, in, 1, position request valid.
- pos_ready, out, 1, position request accepted when high together with pos_valid.
- mem_addr, out, ADDR_W, image memory read address.
- mem_rdata, in, PIX_W, image memory read data.
- memRGB, out, PIX_W, pixel colour.
- in_image, out, 1, memRGB comes from the image.

Function
REQ-009 SHALL detect a FRAME_CLOCK rising edge as a 1 in the current sample with a 0 in the previous registered sample.
REQ-010 Position handshake: when pos_valid and pos_ready are both high, SHALL capture pos_x, pos_y and pos_flip into pending registers, then drive pos_ready low.
REQ-011 SHALL ignore pos_valid while pos_ready is low.
REQ-012 SHALL copy pending to active origin/flip on the next detected frame edge, then drive pos_ready high the following cycle.
REQ-013 A request accepted in the same cycle as a frame edge SHALL apply at the following frame edge, not the current one.
REQ-014 Stage 1, at the edge sampling x and y, SHALL register dx = x - org_x and dy = y - org_y as 11-bit signed values.
REQ-015 Stage 1 SHALL register inside = (0 <= dx < IMG_W<<SCALE_LOG2) and (0 <= dy < IMG_H<<SCALE_LOG2).
REQ-016 Stage 2, one edge later, SHALL register mem_addr = IMG_W*row + col, truncated to ADDR_W, where row = dy>>SCALE_LOG2 and col = dx>>SCALE_LOG2.
REQ-017 When flip is active, stage 2 SHALL use col = IMG_W-1-(dx>>SCALE_LOG2).
REQ-018 When inside is 0, stage 2 SHALL set mem_addr to 0.
REQ-019 The inside flag SHALL be delayed MEM_LAT+1 cycles through a shift register.
REQ-020 The output stage SHALL register memRGB = inside ? mem_rdata : BG_COLOR and in_image = inside.
REQ-021 Latency SHALL be fixed: x and y sampled at edge k SHALL produce mem_addr after edge k+1 and memRGB and in_image after edge k+2+MEM_LAT.
REQ-022 Throughput SHALL be one pixel per cycle, with no stalls.
REQ-023 An origin change SHALL take effect only on a frame edge; mid-frame pos_* changes SHALL never affect the output.

Reset
REQ-024 On RST_IN high at a clock edge, SHALL set: active origin (0,0); flip 0; pending cleared; pos_ready 1; edge detector sample 0.
REQ-025 On reset SHALL also set: all stage flags 0; mem_addr 0; memRGB BG_COLOR; in_image 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending request and any in-flight pixels.

Verification
REQ-027 After reset, x=5, y=9 -> mem_addr=321 after 1 edge; memRGB=mem[321] and in_image=1 after 3 edges.
REQ-028 Request (100,50), then a frame edge; x=99,y=50 -> memRGB=BG_COLOR, in_image=0; x=100,y=50 -> mem_addr=0, in_image=1.
REQ-029 Two pos_valid pulses before a frame edge -> only the first is accepted; pos_ready stays 0 until the cycle after the edge; the second value is ignored.
REQ-030 Origin (0,0) with flip=1 applied, x=0,y=0 -> mem_addr=159; x=639,y=0 -> mem_addr=0.
REQ-031 Origin (0,0): x=639,y=479 -> mem_addr=19199, in_image=1; x=639,y=480 -> mem_addr=0, in_image=0, memRGB=BG_COLOR.
REQ-032 Pending request (200,200) with RST_IN pulsed before the frame edge -> after the edge the origin stays (0,0) and pos_ready=1.
